// File: rtl/text_pkg.sv
// Shared constants, types and address helper for the text-mode pixel source.
package text_pkg;
  localparam int COLS   = 70;
  localparam int ROWS   = 30;
  localparam int CELL_W = 9;
  localparam int CELL_H = 16;
  localparam int NCELLS = COLS * ROWS;

  localparam logic [7:0] SPACE      = 8'h20;
  localparam logic [2:0] FG_DEFAULT = 3'd7;

  localparam logic [23:0] PALETTE [8] = '{
    24'h000000, 24'hFF0000, 24'h00FF00, 24'hFFFF00,
    24'h0000FF, 24'hFF00FF, 24'h00FFFF, 24'hFFFFFF
  };

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_e;

  typedef struct packed {
    logic [7:0] ch;
    logic [2:0] fg;
  } cell_t;

  // Per-pixel side information travelling with the buffer/font lookups.
  typedef struct packed {
    logic [3:0] subx;
    logic       blank;
    logic       hit;
  } pix_tag_t;

  // row*70 + col without a multiplier: 64r + 4r + 2r + c.
  function automatic logic [11:0] cell_addr(input logic [5:0] row, input logic [6:0] col);
    logic [11:0] r;
    r = {6'd0, row};
    return (r << 6) + (r << 2) + (r << 1) + {5'd0, col};
  endfunction
endpackage

// File: rtl/text_pixel_gen_if.sv
// VGA-side scan inputs, cell write port, cursor controls and pixel output.
interface text_pixel_gen_if;
  logic [9:0]  h_addr;
  logic [9:0]  v_addr;
  logic        valid;
  logic        wr_en;
  logic [6:0]  wr_col;
  logic [4:0]  wr_row;
  logic [7:0]  wr_char;
  logic [2:0]  wr_fg;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic        cur_en;
  logic        clr;
  logic        busy;
  logic [23:0] bits;

  modport master (
    output h_addr, v_addr, valid, wr_en, wr_col, wr_row, wr_char, wr_fg,
           cur_col, cur_row, cur_en, clr,
    input  busy, bits
  );

  modport slave (
    input  h_addr, v_addr, valid, wr_en, wr_col, wr_row, wr_char, wr_fg,
           cur_col, cur_row, cur_en, clr,
    output busy, bits
  );
endinterface

// File: rtl/text_pixel_gen_font_rom.sv
// 4096x8 synchronous glyph ROM addressed by {char, line}; one-cycle registered output.
module font_rom
  import text_pkg::*;
(
  input  logic        clk,
  input  logic [11:0] i_addr,
  output logic [7:0]  o_data
);
  localparam logic [7:0] GLYPH_A [16] = '{
    8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
    8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00
  };

  logic [7:0] r_data;
  logic [7:0] w_row;

  // Resident glyphs: 'A' and the full block 0xDB; all other codes render blank.
  always_comb begin
    w_row = 8'h00;
    case (i_addr[11:4])
      8'h41:   w_row = GLYPH_A[i_addr[3:0]];
      8'hDB:   w_row = 8'hFF;
      default: w_row = 8'h00;
    endcase
  end

  always_ff @(posedge clk) r_data <= w_row;

  assign o_data = r_data;
endmodule

// File: rtl/text_pixel_gen.sv
// 70x30 text buffer rendered through the font ROM into 24-bit pixels, 3-cycle latency.
module text_pixel_gen
  import text_pkg::*;
#(
  parameter int BLINK_BIT = 4
) (
  input  logic           pclk,
  input  logic           reset,
  text_pixel_gen_if.slave bus
);
  state_e      r_state, w_state_nxt;
  logic [11:0] r_sweep, w_sweep_nxt;
  logic        w_busy, w_we, w_wr_ok;
  logic [11:0] w_waddr, w_raddr;
  cell_t       w_wdata;

  assign w_wr_ok = bus.wr_en && (bus.wr_col < 7'(COLS)) && (bus.wr_row < 5'(ROWS));

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_CLEAR;
      r_sweep <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sweep <= w_sweep_nxt;
    end
  end

  // The sweep owns the single write port; user writes only land in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep;
    w_busy      = 1'b0;
    w_we        = 1'b0;
    w_waddr     = cell_addr({1'b0, bus.wr_row}, bus.wr_col);
    w_wdata     = '{ch: bus.wr_char, fg: bus.wr_fg};
    case (r_state)
      ST_CLEAR: begin
        w_busy  = 1'b1;
        w_we    = 1'b1;
        w_waddr = r_sweep;
        w_wdata = '{ch: SPACE, fg: FG_DEFAULT};
        if (r_sweep == 12'(NCELLS - 1)) begin
          w_state_nxt = ST_IDLE;
          w_sweep_nxt = '0;
        end else begin
          w_sweep_nxt = r_sweep + 12'd1;
        end
      end
      default: begin
        w_we = w_wr_ok;
        if (bus.clr) w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  assign bus.busy = w_busy;

  logic [3:0] r_subx;
  logic [6:0] r_col;

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      r_subx <= '0;
      r_col  <= '0;
    end else if (!bus.valid) begin
      r_subx <= '0;
      r_col  <= '0;
    end else if (r_subx == 4'(CELL_W - 1)) begin
      r_subx <= '0;
      if (r_col != 7'(COLS)) r_col <= r_col + 7'd1;
    end else begin
      r_subx <= r_subx + 4'd1;
    end
  end

  logic       r_valid_q;
  logic [4:0] r_frame;
  logic       w_blink;

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      r_valid_q <= 1'b0;
      r_frame   <= '0;
    end else begin
      r_valid_q <= bus.valid;
      if (bus.valid && !r_valid_q && bus.v_addr == '0) r_frame <= r_frame + 5'd1;
    end
  end

  assign w_blink = r_frame[BLINK_BIT];

  // Right margin (col 70) and rows past the buffer read a harmless in-range cell.
  assign w_raddr = (r_col < 7'(COLS) && bus.v_addr[9:4] < 6'(ROWS))
                 ? cell_addr(bus.v_addr[9:4], r_col) : '0;

  cell_t r_mem [NCELLS];
  cell_t r_rd;

  always_ff @(posedge pclk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    r_rd <= r_mem[w_raddr];
  end

  pix_tag_t   w_tag0, r_tag1, r_tag2;
  logic [2:1] r_vld_pipe;
  logic [3:0] r_line1;
  logic [2:0] r_fg2;
  logic [7:0] w_font;
  logic [23:0] r_bits;
  logic       w_pix;

  assign w_tag0.subx  = r_subx;
  assign w_tag0.blank = (r_col == 7'(COLS));
  assign w_tag0.hit   = bus.cur_en && w_blink && (r_col == bus.cur_col)
                     && (bus.v_addr[9:4] == {1'b0, bus.cur_row})
                     && (bus.v_addr[3:1] == 3'b111);

  font_rom u_font (
    .clk    (pclk),
    .i_addr ({r_rd.ch, r_line1}),
    .o_data (w_font)
  );

  assign w_pix = (r_tag2.subx != 4'(CELL_W - 1)) && w_font[3'd7 - r_tag2.subx[2:0]];

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      r_vld_pipe <= '0;
      r_tag1     <= '0;
      r_tag2     <= '0;
      r_line1    <= '0;
      r_fg2      <= '0;
      r_bits     <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[1], bus.valid};
      r_tag1     <= w_tag0;
      r_line1    <= bus.v_addr[3:0];
      r_tag2     <= r_tag1;
      r_fg2      <= r_rd.fg;
      if (!r_vld_pipe[2] || r_tag2.blank) r_bits <= 24'h000000;
      else if (r_tag2.hit)                r_bits <= 24'hFFFFFF;
      else if (w_pix)                     r_bits <= PALETTE[r_fg2];
      else                                r_bits <= 24'h000000;
    end
  end

  assign bus.bits = r_bits;

  // h_addr is implied by the column counters and kept only for interface symmetry.
  logic w_unused_h;
  assign w_unused_h = ^bus.h_addr;
endmodule
